// File: rtl/s386w_bist_driver.sv
// BIST driver for the s386w block: LFSR stimulus on CUT_IN, MISR compaction of CUT_OUT,
// and a pass/fail verdict against a golden signature.
module s386w_bist_driver #(
  parameter int unsigned N_PATTERNS   = 1000,
  parameter int unsigned FLUSH_CYCLES = 8,
  parameter logic [6:0]  FLUSH_VEC    = 7'h00,
  parameter logic [6:0]  LFSR_SEED    = 7'h01,
  parameter logic [6:0]  MISR_SEED    = 7'h00,
  parameter logic [6:0]  GOLDEN_SIG   = 7'h00,
  parameter int unsigned CNT_W        = 16
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       VDD,
  input  logic       VSS,
  input  logic       START,
  input  logic       ABORT,
  input  logic [6:0] CUT_OUT,
  output logic [6:0] CUT_IN,
  output logic       BUSY,
  output logic       DONE,
  output logic       PASS,
  output logic [6:0] SIGNATURE
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FLUSH = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // An all-zero LFSR would lock up, so a zero seed is promoted to 7'h01.
  localparam logic [6:0] LFSR_INIT = (LFSR_SEED == 7'h00) ? 7'h01 : LFSR_SEED;
  localparam logic [CNT_W-1:0] FLUSH_LAST =
    CNT_W'((FLUSH_CYCLES == 0) ? 0 : FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] RUN_LAST =
    CNT_W'((N_PATTERNS == 0) ? 0 : N_PATTERNS - 1);
  localparam logic [1:0] ST_FIRST = (FLUSH_CYCLES == 0) ? ST_RUN : ST_FLUSH;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [6:0]       lfsr_q, lfsr_d;
  logic [6:0]       misr_q, misr_d;
  logic [6:0]       cut_in_q, cut_in_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;

  logic unused_supply;
  assign unused_supply = VDD ^ VSS;

  // Next state, datapath and registered-output values.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    lfsr_d   = lfsr_q;
    misr_d   = misr_q;
    cnt_inc  = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (START) begin
          state_d = ST_FIRST;
          cnt_d   = '0;
          lfsr_d  = LFSR_INIT;
          misr_d  = MISR_SEED;
        end
      end
      ST_FLUSH: begin
        if (cnt_q == FLUSH_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_RUN: begin
        misr_d = {misr_q[5:0], misr_q[6] ^ misr_q[5]} ^ CUT_OUT;
        lfsr_d = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
        if (cnt_q == RUN_LAST) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (ABORT) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      lfsr_d  = LFSR_INIT;
      misr_d  = MISR_SEED;
    end

    // Stimulus follows the next state so CUT_IN moves on the same edge as the state.
    cut_in_d = (state_d == ST_RUN) ? lfsr_d : FLUSH_VEC;
    busy_d   = (state_d == ST_FLUSH) || (state_d == ST_RUN);
    done_d   = (state_d == ST_DONE);
    pass_d   = done_d && (misr_d == GOLDEN_SIG);
  end

  // State and output registers.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      lfsr_q   <= LFSR_INIT;
      misr_q   <= MISR_SEED;
      cut_in_q <= FLUSH_VEC;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lfsr_q   <= lfsr_d;
      misr_q   <= misr_d;
      cut_in_q <= cut_in_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
    end
  end

  assign CUT_IN    = cut_in_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign PASS      = pass_q;
  assign SIGNATURE = misr_q;

endmodule

// File: tb/tb_s386w_bist_driver.sv
// Bench for s386w_bist_driver: two instances (2/8 and 0/128 flush/run lengths) checked
// every cycle against a start-relative timeline model, plus hand-computed literals.
module tb_s386w_bist_driver;

  localparam int         FA = 2;
  localparam int         NA = 8;
  localparam int         FB = 0;
  localparam int         NB = 128;
  localparam logic [6:0] GA = 7'h7D;
  localparam logic [6:0] GB = 7'h00;
  localparam logic [6:0] FV = 7'h00;
  localparam logic [6:0] LS = 7'h01;
  localparam logic [6:0] MS = 7'h00;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start_a = 1'b0, abort_a = 1'b0, start_b = 1'b0, abort_b = 1'b0;
  logic       fault_a = 1'b0;
  logic [6:0] noise_a = 7'h00, noise_b = 7'h00;
  logic [6:0] cut_in_a, cut_out_a, sig_a, cut_in_b, cut_out_b, sig_b;
  logic       busy_a, done_a, pass_a, busy_b, done_b, pass_b;
  logic       cmp_en = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  int         m_ph   [2];
  int         m_i    [2];
  logic [6:0] m_misr [2];

  always #5 clk = ~clk;

  s386w_bist_driver #(
    .N_PATTERNS(NA), .FLUSH_CYCLES(FA), .FLUSH_VEC(FV), .LFSR_SEED(LS),
    .MISR_SEED(MS), .GOLDEN_SIG(GA), .CNT_W(16)
  ) u_a (
    .CLOCK(clk), .RESET(rst), .VDD(1'b1), .VSS(1'b0), .START(start_a), .ABORT(abort_a),
    .CUT_OUT(cut_out_a), .CUT_IN(cut_in_a), .BUSY(busy_a), .DONE(done_a), .PASS(pass_a),
    .SIGNATURE(sig_a)
  );

  s386w_bist_driver #(
    .N_PATTERNS(NB), .FLUSH_CYCLES(FB), .FLUSH_VEC(FV), .LFSR_SEED(LS),
    .MISR_SEED(MS), .GOLDEN_SIG(GB), .CNT_W(16)
  ) u_b (
    .CLOCK(clk), .RESET(rst), .VDD(1'b1), .VSS(1'b0), .START(start_b), .ABORT(abort_b),
    .CUT_OUT(cut_out_b), .CUT_IN(cut_in_b), .BUSY(busy_b), .DONE(done_b), .PASS(pass_b),
    .SIGNATURE(sig_b)
  );

  // Stand-in circuit under test: bit 0 inverted, optional bit-3 stuck-at-0, optional noise.
  function automatic logic [6:0] cut_fn(input logic [6:0] x, input logic flt);
    logic [6:0] y;
    y = x ^ 7'h01;
    if (flt) y[3] = 1'b0;
    return y;
  endfunction

  always_comb cut_out_a = cut_fn(cut_in_a, fault_a) ^ noise_a;
  always_comb cut_out_b = cut_fn(cut_in_b, 1'b0) ^ noise_b;

  function automatic int f_of(input int n);
    return (n == 0) ? FA : FB;
  endfunction

  function automatic int n_of(input int n);
    return (n == 0) ? NA : NB;
  endfunction

  function automatic logic [6:0] g_of(input int n);
    return (n == 0) ? GA : GB;
  endfunction

  // k-th LFSR pattern after the seed, stepping x^7+x^6+1 from scratch.
  function automatic logic [6:0] lfsr_at(input int k);
    logic [6:0] v;
    v = LS;
    for (int s = 0; s < (k % 127); s++) v = {v[5:0], v[6] ^ v[5]};
    return v;
  endfunction

  function automatic logic [6:0] misr_next(input logic [6:0] m, input logic [6:0] d);
    return {m[5:0], m[6] ^ m[5]} ^ d;
  endfunction

  // Model phase: 0 idle, 1 active (m_i cycles since start), 2 done.
  task automatic model_reset();
    for (int n = 0; n < 2; n++) begin
      m_ph[n] = 0; m_i[n] = 0; m_misr[n] = MS;
    end
  endtask

  task automatic model_step(input int n, input logic s, input logic a, input logic [6:0] co);
    if (a) begin
      m_ph[n] = 0; m_i[n] = 0; m_misr[n] = MS;
    end else if (m_ph[n] != 1 && s) begin
      m_ph[n] = 1; m_i[n] = 0; m_misr[n] = MS;
    end else if (m_ph[n] == 1) begin
      if (m_i[n] >= f_of(n)) m_misr[n] = misr_next(m_misr[n], co);
      m_i[n] = m_i[n] + 1;
      if (m_i[n] == f_of(n) + n_of(n)) m_ph[n] = 2;
    end
  endtask

  function automatic logic [6:0] exp_cut(input int n);
    return (m_ph[n] == 1 && m_i[n] >= f_of(n)) ? lfsr_at(m_i[n] - f_of(n)) : FV;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else begin
      model_step(0, start_a, abort_a, cut_out_a);
      model_step(1, start_b, abort_b, cut_out_b);
    end
  end

  task automatic chk(input string nm, input logic [6:0] act, input logic [6:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_inst(input int n, input logic [6:0] ci, input logic b, input logic d,
                          input logic p, input logic [6:0] sg);
    string t;
    t = (n == 0) ? "a" : "b";
    chk({t, ".cut_in"}, ci, exp_cut(n));
    chk({t, ".busy"}, {6'd0, b}, {6'd0, m_ph[n] == 1});
    chk({t, ".done"}, {6'd0, d}, {6'd0, m_ph[n] == 2});
    chk({t, ".pass"}, {6'd0, p}, {6'd0, m_ph[n] == 2 && m_misr[n] == g_of(n)});
    chk({t, ".signature"}, sg, m_misr[n]);
  endtask

  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      cmp_inst(0, cut_in_a, busy_a, done_a, pass_a, sig_a);
      cmp_inst(1, cut_in_b, busy_b, done_b, pass_b, sig_b);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_start_a();
    start_a = 1'b1;
    cyc();
    start_a = 1'b0;
  endtask

  task automatic wait_done_a(input int maxc, output int cnt);
    cnt = 0;
    while (!done_a && cnt < maxc) begin
      cyc();
      cnt++;
    end
    if (!done_a) begin
      miscompares++;
      $display("FAIL wait_done_a: DONE not seen within %0d cycles", maxc);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] seq [10];
    int         nc;
    seq = '{7'h00, 7'h00, 7'h01, 7'h02, 7'h04, 7'h08, 7'h10, 7'h20, 7'h41, 7'h03};

    #1 rst = 1'b1;
    #2;
    chk("reset.cut_in", cut_in_a, 7'h00);
    chk("reset.signature", sig_a, 7'h00);
    chk("reset.busy_done_pass", {4'd0, busy_a, done_a, pass_a}, 7'h00);
    #9 rst = 1'b0;
    cmp_en = 1'b1;
    cyc();

    // Flush 2 + run 8: literal stimulus sequence and signature.
    pulse_start_a();
    for (int j = 0; j < 10; j++) begin
      chk($sformatf("t1.cut_in[%0d]", j), cut_in_a, seq[j]);
      chk($sformatf("t1.busy[%0d]", j), {6'd0, busy_a}, 7'h01);
      cyc();
    end
    chk("t1.done", {6'd0, done_a}, 7'h01);
    chk("t1.busy_after", {6'd0, busy_a}, 7'h00);
    chk("t1.signature", sig_a, 7'h7D);
    chk("t2.pass", {6'd0, pass_a}, 7'h01);

    // Bit 3 stuck-at-0 must change the signature and fail.
    fault_a = 1'b1;
    pulse_start_a();
    chk("t4.done_drops", {6'd0, done_a}, 7'h00);
    wait_done_a(40, nc);
    chk("t2.fault_signature", sig_a, 7'h7E);
    chk("t2.fault_pass", {6'd0, pass_a}, 7'h00);
    fault_a = 1'b0;

    // START during FLUSH and RUN is ignored; DONE timing unchanged.
    pulse_start_a();
    for (int j = 0; j < 10; j++) begin
      chk($sformatf("t4.not_done[%0d]", j), {6'd0, done_a}, 7'h00);
      start_a = (j == 1 || j == 5);
      cyc();
    end
    start_a = 1'b0;
    chk("t4.done_on_time", {6'd0, done_a}, 7'h01);
    chk("t4.signature", sig_a, 7'h7D);
    pulse_start_a();
    chk("t4.restart_done_drops", {6'd0, done_a}, 7'h00);
    wait_done_a(40, nc);
    chk("t4.restart_latency", 7'(nc), 7'd10);
    chk("t4.restart_signature", sig_a, 7'h7D);

    // ABORT in RUN cycle 3, then ABORT+START together in IDLE.
    pulse_start_a();
    repeat (5) cyc();
    chk("t5.run3_cut_in", cut_in_a, 7'h08);
    abort_a = 1'b1;
    cyc();
    abort_a = 1'b0;
    chk("t5.abort_cut_in", cut_in_a, 7'h00);
    chk("t5.abort_busy", {6'd0, busy_a}, 7'h00);
    chk("t5.abort_signature", sig_a, 7'h00);
    abort_a = 1'b1;
    start_a = 1'b1;
    cyc();
    abort_a = 1'b0;
    start_a = 1'b0;
    chk("t5.abort_start_busy", {6'd0, busy_a}, 7'h00);
    cyc();
    chk("t5.start_not_remembered", {6'd0, busy_a}, 7'h00);

    // Flush 0 + run 128: wrap to the seed in run cycle 127, DONE 128 cycles after START.
    start_b = 1'b1;
    cyc();
    start_b = 1'b0;
    chk("t3.first_cut_in", cut_in_b, 7'h01);
    repeat (127) cyc();
    chk("t3.wrap_cut_in", cut_in_b, 7'h01);
    chk("t3.not_done_127", {6'd0, done_b}, 7'h00);
    cyc();
    chk("t3.done_128", {6'd0, done_b}, 7'h01);

    // Asynchronous reset between edges mid-RUN.
    pulse_start_a();
    repeat (4) cyc();
    #1 rst = 1'b1;
    #1;
    chk("t6.rst_cut_in", cut_in_a, 7'h00);
    chk("t6.rst_signature", sig_a, 7'h00);
    chk("t6.rst_busy_done_pass", {4'd0, busy_a, done_a, pass_a}, 7'h00);
    repeat (2) cyc();
    rst = 1'b0;
    cyc();
    pulse_start_a();
    wait_done_a(40, nc);
    chk("t6.signature", sig_a, 7'h7D);
    chk("t6.pass", {6'd0, pass_a}, 7'h01);

    // Random START/ABORT traffic and CUT_OUT noise against the model.
    for (int c = 0; c < 2500; c++) begin
      start_a = ($urandom_range(0, 15) == 0);
      abort_a = ($urandom_range(0, 59) == 0);
      start_b = ($urandom_range(0, 15) == 0);
      abort_b = ($urandom_range(0, 199) == 0);
      noise_a = 7'($urandom);
      noise_b = 7'($urandom);
      cyc();
    end
    start_a = 1'b0; abort_a = 1'b0; start_b = 1'b0; abort_b = 1'b0;
    noise_a = 7'h00; noise_b = 7'h00;
    repeat (4) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
